mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It consumes the EX/MEM pipeline register outputs and performs loads and stores over a request/grant/response data-memory bus. It returns the stage's forwarding value to the execute stage and holds the MEM/WB pipeline register. A small FSM stalls the pipeline until the memory transaction completes.

## Interface
Parameters:
- BUS_TIMEOUT, 255: maximum cycles spent waiting in REQ or RESP before the access is abandoned. Minimum 1.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- ALUData  in  32  effective address, or ALU result for non-memory instructions
- DataB  in  32  forwarded store data
- funct3  in  3  load/store width and sign
- MemRW  in  1  1 = store
- RegWEn  in  1  register write enable
- AddrD  in  5  destination register
- WBSel  in  2  2'b00 = load (memory data); 2'b01 = ALU; 2'b10 = PC+4
- PC  in  32  instruction PC
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read word
- DataM  out  32  combinational forward to EX; equals ALUData
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misaligned  out  1  one-cycle pulse on a misaligned access
- bus_err  out  1  one-cycle pulse on timeout
- DataMem_out, ALUData_out, PC_out  out  32 each  MEM/WB register
- AddrD_out  out  5  MEM/WB register
- RegWEn_out  out  1  MEM/WB register
- WBSel_out  out  2  MEM/WB register

## Operation
- An access is any store (MemRW = 1) or any load (WBSel = 00 with MemRW = 0). Otherwise the stage is a pass-through into MEM/WB.
- Alignment rules:
  - Byte: always legal.
  - Halfword: requires ALUData[0] = 0.
  - Word: requires ALUData[1:0] = 0.
- A misaligned access never raises dmem_req. It pulses misaligned, writes MEM/WB with RegWEn_out = 0, and does not stall.
- Store lanes, with a = ALUData[1:0]:
  - SB (000): be = 0001 << a, wdata = {4{DataB[7:0]}}.
  - SH (001): be = 0011 << a, wdata = {2{DataB[15:0]}}.
  - SW (010): be = 1111.
- Load extraction: select the byte or halfword at offset a.
  - LB (000) and LH (001): sign-extend.
  - LBU (100) and LHU (101): zero-extend.
  - LW (010): whole word.
  - Any other funct3 is treated as LW/SW width.
- FSM states: IDLE, REQ, RESP.
  - IDLE, legal access: dmem_req = 1 combinationally. On gnt, a store completes with no stall; a load moves to RESP. Without gnt, move to REQ.
  - REQ: hold dmem_req and all bus fields stable until gnt. On gnt, a store returns to IDLE; a load moves to RESP.
  - RESP: wait for rvalid, capture the extended data, return to IDLE.
- stall = 1 whenever the current access has not completed in this cycle.
- While stalled, MEM/WB receives a bubble: RegWEn_out = 0, other fields don't care.
- Timeout: a counter clears on every state entry and increments in REQ and RESP. When it reaches BUS_TIMEOUT:
  - pulse bus_err, drop dmem_req, return to IDLE;
  - complete the instruction with RegWEn_out = 0.

## Timing
- Reset values: state IDLE, counter 0, every MEM/WB output 0, dmem_req = 0, misaligned = 0, bus_err = 0.
- Latency:
  - Non-memory instruction: one cycle into MEM/WB.
  - Store: 0 stall cycles when gnt arrives in the same cycle as the request.
  - Load: at least 1 stall cycle, since rvalid arrives no earlier than the cycle after gnt.
- Load data reaches DataMem_out on the clock edge that samples rvalid.
- rvalid in IDLE or REQ is ignored, including a late response after timeout or reset.
- gnt and rvalid asserted together in the request cycle: accept the grant only; rvalid is honoured from RESP.
- Reset asserted mid-transaction: return to IDLE on the next edge and deassert dmem_req. Outstanding responses are discarded.
- Upstream must hold its EX/MEM register outputs constant while stall = 1.

## Structure
- Package riscv_mem_pkg holds:
  - the funct3 load/store constants;
  - the WBSel encodings;
  - the FSM state enum (IDLE, REQ, RESP).
- One sub-module, mem_align: purely combinational. Produces be and wdata, and performs load extraction/extension. The FSM, counter and MEM/WB register stay in mem_stage.

## Test plan
- SB: ALUData = 0x1003, DataB = 0xAB, gnt same cycle -> dmem_be = 1000, dmem_wdata = 0xABABABAB, dmem_addr = 0x1000, stall = 0.
- LB: ALUData = 0x2001, gnt at cycle 0, rvalid at cycle 2 with rdata = 0x00008000 -> stall high for 2 cycles, DataMem_out = 0xFFFFFF80. Same sequence with LBU -> 0x00000080.
- LW with gnt delayed 3 cycles -> dmem_req and dmem_addr held stable in REQ, bubbles in MEM/WB (RegWEn_out = 0) until completion.
- LH at 0x3001 -> misaligned pulses, dmem_req never asserted, RegWEn_out = 0, no stall.
- BUS_TIMEOUT = 4, gnt never asserted -> bus_err pulses after 4 cycles in REQ, state IDLE, a later rvalid is ignored.
- Reset asserted in RESP -> the next edge gives dmem_req = 0, all MEM/WB outputs 0, state IDLE.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: load/store width codes, writeback select encodings and memory FSM states
package riscv_mem_pkg;
  localparam logic [2:0] F3_B = 3'b000, F3_H = 3'b001, F3_W = 3'b010, F3_BU = 3'b100, F3_HU = 3'b101;
  localparam logic [1:0] WB_MEM = 2'b00, WB_ALU = 2'b01, WB_PC = 2'b10;
  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane steering, alignment check and load extraction for byte/half/word accesses
module mem_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        store,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        aligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);
  logic is_byte, is_half;
  logic [31:0] shifted;
  always_comb begin
    is_byte = funct3 == F3_B || (!store && funct3 == F3_BU);
    is_half = funct3 == F3_H || (!store && funct3 == F3_HU);
    aligned = is_byte || (is_half ? !offset[0] : offset == 2'b00);
    be = is_byte ? 4'b0001 << offset : is_half ? 4'b0011 << offset : 4'b1111;
    wdata = is_byte ? {4{store_data[7:0]}} : is_half ? {2{store_data[15:0]}} : store_data;
    shifted = rdata >> {offset, 3'b000};
    load_data = is_byte ? {{24{shifted[7] & !funct3[2]}}, shifted[7:0]}
              : is_half ? {{16{shifted[15] & !funct3[2]}}, shifted[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage driving a req/gnt/rvalid data bus with stall FSM and MEM/WB register
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUData,
  input  logic [31:0] DataB,
  input  logic [2:0]  funct3,
  input  logic        MemRW,
  input  logic        RegWEn,
  input  logic [4:0]  AddrD,
  input  logic [1:0]  WBSel,
  input  logic [31:0] PC,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] DataM,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic [31:0] DataMem_out,
  output logic [31:0] ALUData_out,
  output logic [31:0] PC_out,
  output logic [4:0]  AddrD_out,
  output logic        RegWEn_out,
  output logic [1:0]  WBSel_out
);
  localparam int CW = $clog2(BUS_TIMEOUT + 1);
  mem_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic is_load, mem_op, aligned, access, timeout, done;
  logic [31:0] load_data;
  mem_align u_align (
    .funct3(funct3),
    .store(MemRW),
    .offset(ALUData[1:0]),
    .store_data(DataB),
    .rdata(dmem_rdata),
    .aligned(aligned),
    .be(dmem_be),
    .wdata(dmem_wdata),
    .load_data(load_data)
  );
  assign DataM = ALUData;
  assign dmem_addr = {ALUData[31:2], 2'b00};
  assign dmem_we = MemRW;
  always_comb begin
    is_load = !MemRW && WBSel == WB_MEM;
    mem_op = MemRW || is_load;
    access = mem_op && aligned;
    timeout = state != IDLE && cnt == CW'(BUS_TIMEOUT);
    done = timeout || (state == RESP ? dmem_rvalid : (state == REQ || access) ? dmem_gnt && MemRW : 1'b1);
    state_n = (timeout || done) ? IDLE : (dmem_gnt && state != RESP) ? RESP : state == IDLE ? REQ : state;
    dmem_req = !reset && !timeout && (state == REQ || (state == IDLE && access));
    stall = !reset && !done;
    misaligned = !reset && state == IDLE && mem_op && !aligned;
    bus_err = !reset && timeout;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      DataMem_out <= '0;
      ALUData_out <= '0;
      PC_out <= '0;
      AddrD_out <= '0;
      RegWEn_out <= 1'b0;
      WBSel_out <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == RESP && dmem_rvalid && !timeout) DataMem_out <= load_data;
      ALUData_out <= ALUData;
      PC_out <= PC;
      AddrD_out <= AddrD;
      WBSel_out <= WBSel;
      RegWEn_out <= RegWEn && done && !timeout && !misaligned;
    end
  end
endmodule
